cd_spi2csr: RTL and testbench
=============================

CD_SPI2CSR -- requirements
Module: cd_spi2csr

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, the number of flip-flop stages synchronizing each of sclk, nss and mosi to clk (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port sclk, input, 1 bit, the SPI clock (mode 0, CPOL=0, CPHA=0), at most clk/8.
REQ-005 The block SHALL have port nss, input, 1 bit, the SPI select, active-low, framing one transaction.
REQ-006 The block SHALL have port mosi, input, 1 bit, the SPI data in.
REQ-007 The block SHALL have port miso, output, 1 bit, the SPI data out.
REQ-008 The block SHALL have port miso_en, output, 1 bit, the MISO tristate enable; it SHALL be high exactly while the synchronized nss is low.
REQ-009 The block SHALL have port csr_address, output, 4 bits, the CSR register address.
REQ-010 The block SHALL have port csr_byteenable, output, 4 bits, the CSR byte lane enable.
REQ-011 The block SHALL have port csr_read, output, 1 bit, a one-cycle CSR read strobe.
REQ-012 The block SHALL have port csr_readdata, input, 32 bits, combinational read data valid in the cycle csr_read is high.
REQ-013 The block SHALL have port csr_write, output, 1 bit, a one-cycle CSR write strobe.
REQ-014 The block SHALL have port csr_writedata, output, 32 bits, the CSR write data.

Function
REQ-015 sclk, nss and mosi SHALL each pass through SYNC_STAGES flops; sclk rising and falling edges SHALL be detected on the synchronized signal.
REQ-016 Frame format SHALL be: byte0 = command {W[7], 3'b000, ADDR[6:3] ignored... no: bits[6:4] reserved, ADDR[3:0]}, then data bytes 0..3; bits MSB-first within a byte; data bytes little-endian (byte k = lane k).
REQ-017 The state machine SHALL have states IDLE, CMD, DATA and OVER.
REQ-018 IDLE->CMD SHALL occur on nss falling, clearing the bit counter (3 bits) and the byte counter (3 bits).
REQ-019 mosi SHALL be sampled on each sclk rising edge; on the 8th rise in CMD the block SHALL latch csr_address = ADDR and the W flag, then transition CMD->DATA.
REQ-020 Read (W=0): csr_read SHALL pulse for exactly 1 clk, 1 clk after the 8th command rise is detected, with the new csr_address already stable; csr_readdata SHALL be captured into a 32-bit shift register in that same cycle.
REQ-021 There SHALL be exactly one csr_read per frame, regardless of how many data bytes are clocked, because reads can have side effects (e.g. flag clearing).
REQ-022 Read data SHALL be driven on miso: the MSB of lane 0 valid after the 8th sclk falling edge of the command byte; each subsequent bit SHALL update on an sclk falling edge; order SHALL be lane0[7]..lane0[0], lane1[7]..lane3[0].
REQ-023 Write (W=1): on the 8th rise of data byte k, the block SHALL issue csr_write for 1 clk with csr_byteenable = 4'b0001<<k and csr_writedata = {4{byte}} (the byte replicated in all lanes).
REQ-024 csr_byteenable SHALL be 0 whenever csr_write is low.
REQ-025 After data byte 3 completes, DATA->OVER; in OVER, mosi SHALL be ignored, no CSR strobes SHALL occur, and miso SHALL be 0.
REQ-026 miso SHALL be 0 during the command byte and for write frames.
REQ-027 csr_address SHALL hold its value until the next command byte completes.
REQ-028 nss rising in any state SHALL return to IDLE within 1 clk; a partial byte SHALL be discarded with no strobe issued; a strobe already in flight SHALL complete its single cycle.
REQ-029 sclk edges while nss is high SHALL be ignored.
REQ-030 csr_read and csr_write SHALL never be high in the same cycle.

Reset
REQ-031 While reset_n is low, the block SHALL be in state IDLE, all synchronizers SHALL hold nss=1 and sclk=0, and csr_address, csr_byteenable, csr_writedata, csr_read, csr_write, miso and miso_en SHALL all be 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh nss falling edge before accepting a frame.

Verification
REQ-033 Write command 0x87 followed by data 0x34, 0x12 -> two csr_write pulses at address 7: first byteenable 0001 with writedata 0x34343434, then byteenable 0010 with writedata 0x12121212; no csr_read.
REQ-034 Read command 0x09 with 4 dummy bytes and csr_readdata=0x000000A5 -> exactly one csr_read at address 9; MISO bytes shift out as A5, 00, 00, 00.
REQ-035 Read command 0x00 with csr_readdata=0x0E and 6 bytes clocked -> MISO bytes are 0E, 00, 00, 00, 00, then 00 in OVER; still exactly one csr_read.
REQ-036 Write command 0x81, then nss raised after 5 bits of the data byte -> no csr_write; the next frame (write 0x82, data 0xFF) writes address 2, lane 0, correctly.
REQ-037 reset_n pulsed low during the second data byte of a write frame -> all outputs 0; no further strobes until a new frame begins.
REQ-038 sclk toggled 16 times with nss high -> no strobes, and miso_en stays 0.

Source files
------------

// File: rtl/cd_spi2csr_if.sv
// ----------------------------------------------------------------------------
// cd_spi2csr_if
// CSR-side bus of the SPI-to-CSR bridge.
//   csr_address    : register address, held between command bytes
//   csr_byteenable : one-hot byte lane enable, zero unless csr_write is high
//   csr_read       : one-cycle read strobe
//   csr_readdata   : combinational read data, valid while csr_read is high
//   csr_write      : one-cycle write strobe
//   csr_writedata  : write data (received byte replicated in all lanes)
// The bridge is the master; the register file is the slave.
// ----------------------------------------------------------------------------
interface cd_spi2csr_if;
    logic [3:0]  csr_address;
    logic [3:0]  csr_byteenable;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic        csr_write;
    logic [31:0] csr_writedata;

    modport master (
        output csr_address,
        output csr_byteenable,
        output csr_read,
        input  csr_readdata,
        output csr_write,
        output csr_writedata
    );

    modport slave (
        input  csr_address,
        input  csr_byteenable,
        input  csr_read,
        output csr_readdata,
        input  csr_write,
        input  csr_writedata
    );
endinterface

// File: rtl/cd_spi2csr.sv
// ----------------------------------------------------------------------------
// cd_spi2csr
// SPI (mode 0) slave that turns each nss-framed transaction into CSR accesses.
// Frame: command byte {W, 3 reserved bits, ADDR[3:0]} then up to four data
// bytes, MSB first, byte k mapped to lane k. Writes issue one strobe per data
// byte; reads issue a single strobe after the command byte and shift the
// captured word out on miso. Everything runs in the clk domain; the SPI pins
// are synchronized and sclk edges are detected on the synchronized copy.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   sclk, nss, mosi : SPI inputs (asynchronous to clk)
//   miso, miso_en   : SPI data out and its tristate enable
//   csr             : CSR master port (see cd_spi2csr_if)
// ----------------------------------------------------------------------------
module cd_spi2csr #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sclk,
    input  logic         nss,
    input  logic         mosi,
    output logic         miso,
    output logic         miso_en,
    cd_spi2csr_if.master csr
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        OVER = 2'd3
    } state_t;

    // Reorders the read word so that a plain MSB-first shift emits
    // lane0[7..0], lane1[7..0], lane2[7..0], lane3[7..0].
    function automatic logic [31:0] lane_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    state_t      state_q,       state_d;
    logic [SS-1:0] sclk_sync_q, sclk_sync_d;
    logic [SS-1:0] nss_sync_q,  nss_sync_d;
    logic [SS-1:0] mosi_sync_q, mosi_sync_d;
    logic [SS-1:0] fill_q,      fill_d;
    logic        armed_q,       armed_d;
    logic        sclk_prev_q,   sclk_prev_d;
    logic [2:0]  bit_cnt_q,     bit_cnt_d;
    logic [2:0]  byte_cnt_q,    byte_cnt_d;
    logic [7:0]  rx_q,          rx_d;
    logic        wr_flag_q,     wr_flag_d;
    logic [31:0] tx_q,          tx_d;
    logic        miso_q,        miso_d;
    logic [3:0]  address_q,     address_d;
    logic [3:0]  byteenable_q,  byteenable_d;
    logic        read_q,        read_d;
    logic        write_q,       write_d;
    logic [31:0] writedata_q,   writedata_d;

    logic        sclk_s;
    logic        nss_s;
    logic        mosi_s;
    logic        sync_valid_s;
    logic        sclk_rise_s;
    logic        sclk_fall_s;
    logic [7:0]  rx_byte_s;

    assign sclk_s       = sclk_sync_q[SS-1];
    assign nss_s        = nss_sync_q[SS-1];
    assign mosi_s       = mosi_sync_q[SS-1];
    // fill_q tracks when the synchronizers hold real pin values instead of
    // their reset values.
    assign sync_valid_s = fill_q[SS-1];
    assign sclk_rise_s  = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s  = ~sclk_s & sclk_prev_q;
    assign rx_byte_s    = {rx_q[6:0], mosi_s};

    // Next-state and next-output logic for synchronizers, FSM and CSR strobes.
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SS-2:0], sclk};
        nss_sync_d   = {nss_sync_q[SS-2:0], nss};
        mosi_sync_d  = {mosi_sync_q[SS-2:0], mosi};
        fill_d       = {fill_q[SS-2:0], 1'b1};
        // A frame may only start once nss has been seen high after reset, so a
        // frame cut by reset is not picked up half-way when reset releases.
        armed_d      = armed_q | (sync_valid_s & nss_s);
        sclk_prev_d  = sclk_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        rx_d         = rx_q;
        wr_flag_d    = wr_flag_q;
        tx_d         = tx_q;
        miso_d       = 1'b0;
        address_d    = address_q;
        byteenable_d = 4'b0000;
        read_d       = 1'b0;
        write_d      = 1'b0;
        writedata_d  = writedata_q;

        case (state_q)
            IDLE: begin
                if (armed_q && sync_valid_s && !nss_s) begin
                    state_d    = CMD;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 3'd0;
                    rx_d       = 8'h00;
                end else begin
                    state_d    = IDLE;
                end
            end

            CMD: begin
                if (nss_s) begin
                    state_d = IDLE;
                end else if (sclk_rise_s) begin
                    rx_d      = rx_byte_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        address_d = rx_byte_s[3:0];
                        wr_flag_d = rx_byte_s[7];
                        // Address and strobe update on the same edge, so the
                        // new address is already stable while csr_read is high.
                        read_d    = ~rx_byte_s[7];
                        state_d   = DATA;
                    end else begin
                        state_d   = CMD;
                    end
                end else begin
                    state_d = CMD;
                end
            end

            DATA: begin
                if (nss_s) begin
                    state_d = IDLE;
                end else begin
                    if (read_q) begin
                        tx_d = lane_swap(csr.csr_readdata);
                    end else if (sclk_fall_s && !wr_flag_q) begin
                        tx_d = {tx_q[30:0], 1'b0};
                    end else begin
                        tx_d = tx_q;
                    end

                    if (wr_flag_q) begin
                        miso_d = 1'b0;
                    end else if (sclk_fall_s) begin
                        miso_d = tx_q[31];
                    end else begin
                        miso_d = miso_q;
                    end

                    if (sclk_rise_s) begin
                        rx_d      = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (wr_flag_q) begin
                                write_d      = 1'b1;
                                byteenable_d = 4'b0001 << byte_cnt_q[1:0];
                                writedata_d  = {4{rx_byte_s}};
                            end else begin
                                write_d      = 1'b0;
                            end
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            if (byte_cnt_q == 3'd3) begin
                                state_d = OVER;
                            end else begin
                                state_d = DATA;
                            end
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            OVER: begin
                if (nss_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = OVER;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sclk_sync_q  <= '0;
            nss_sync_q   <= '1;
            mosi_sync_q  <= '0;
            fill_q       <= '0;
            armed_q      <= 1'b0;
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 3'd0;
            rx_q         <= 8'h00;
            wr_flag_q    <= 1'b0;
            tx_q         <= 32'h0000_0000;
            miso_q       <= 1'b0;
            address_q    <= 4'h0;
            byteenable_q <= 4'b0000;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            nss_sync_q   <= nss_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            sclk_prev_q  <= sclk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            rx_q         <= rx_d;
            wr_flag_q    <= wr_flag_d;
            tx_q         <= tx_d;
            miso_q       <= miso_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
        end
    end

    // miso_en follows the last synchronizer stage directly (itself a flop).
    assign miso_en            = ~nss_s;
    assign miso               = miso_q;
    assign csr.csr_address    = address_q;
    assign csr.csr_byteenable = byteenable_q;
    assign csr.csr_read       = read_q;
    assign csr.csr_write      = write_q;
    assign csr.csr_writedata  = writedata_q;

endmodule

// File: tb/tb_cd_spi2csr.sv
`timescale 1ns/1ps
module tb_cd_spi2csr;

    localparam int HALF = 8;   // sclk half period in clk cycles

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
    } csr_txn_t;

    logic        clk;
    logic        reset_n;
    logic        sclk;
    logic        nss;
    logic        mosi;
    logic        miso;
    logic        miso_en;
    logic [31:0] rdata;

    cd_spi2csr_if csr_if ();
    assign csr_if.csr_readdata = rdata;

    cd_spi2csr #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sclk    (sclk),
        .nss     (nss),
        .mosi    (mosi),
        .miso    (miso),
        .miso_en (miso_en),
        .csr     (csr_if.master)
    );

    csr_txn_t   sb[$];
    logic [7:0] miso_exp[$];

    int n_checks = 0;
    int n_pass   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int unexp_cnt = 0;
    int both_cnt  = 0;
    int bad_be_cnt = 0;
    int en_bad_cnt = 0;
    bit nss_high_window = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CSR monitor: pops the scoreboard on each strobe and tracks invariants.
    always @(negedge clk) begin
        csr_txn_t e;
        if (csr_if.csr_read || csr_if.csr_write) begin
            if (csr_if.csr_read && csr_if.csr_write) both_cnt++;
            if (csr_if.csr_read) rd_cnt++;
            if (csr_if.csr_write) wr_cnt++;
            if (sb.size() == 0) begin
                unexp_cnt++;
            end else begin
                e = sb.pop_front();
                check_eq("strobe_kind", {63'd0, csr_if.csr_write}, {63'd0, e.wr});
                check_eq("strobe_addr", {60'd0, csr_if.csr_address}, {60'd0, e.addr});
                if (e.wr) begin
                    check_eq("write_be", {60'd0, csr_if.csr_byteenable}, {60'd0, e.be});
                    check_eq("write_data", {32'd0, csr_if.csr_writedata}, {32'd0, e.data});
                end
            end
        end
        if (!csr_if.csr_write && csr_if.csr_byteenable != 4'b0000) bad_be_cnt++;
        if (nss_high_window && miso_en) en_bad_cnt++;
    end

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_miso"},    {63'd0, miso},    64'd0);
        check_eq({tag, "_miso_en"}, {63'd0, miso_en}, 64'd0);
        check_eq({tag, "_addr"},    {60'd0, csr_if.csr_address},    64'd0);
        check_eq({tag, "_be"},      {60'd0, csr_if.csr_byteenable}, 64'd0);
        check_eq({tag, "_wdata"},   {32'd0, csr_if.csr_writedata},  64'd0);
        check_eq({tag, "_read"},    {63'd0, csr_if.csr_read},       64'd0);
        check_eq({tag, "_write"},   {63'd0, csr_if.csr_write},      64'd0);
    endtask

    // Mode-0 master: mosi set before the rise, miso sampled at the rise.
    task automatic xfer(input string tag, input logic [7:0] mo, input int nbits);
        logic [7:0] mi;
        logic [7:0] e;
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = mo[i];
            repeat (HALF) @(negedge clk);
            sclk  = 1'b1;
            mi[i] = miso;
            repeat (HALF) @(negedge clk);
            sclk  = 1'b0;
        end
        if (nbits == 8) begin
            if (miso_exp.size() == 0) begin
                unexp_cnt++;
            end else begin
                e = miso_exp.pop_front();
                check_eq({tag, "_miso"}, {56'd0, mi}, {56'd0, e});
            end
        end
    endtask

    task automatic frame_start();
        nss = 1'b0;
        repeat (HALF) @(negedge clk);
        check_eq("miso_en_in_frame", {63'd0, miso_en}, 64'd1);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        nss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check_eq("miso_en_after_frame", {63'd0, miso_en}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        reset_n = 1'b0;
        sclk    = 1'b0;
        nss     = 1'b1;
        mosi    = 1'b0;
        rdata   = 32'h0000_0000;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (8) @(negedge clk);

        // Write 0x87, data 0x34, 0x12
        rd0 = rd_cnt; wr0 = wr_cnt;
        sb.push_back('{wr: 1'b1, addr: 4'd7, be: 4'b0001, data: 32'h3434_3434});
        sb.push_back('{wr: 1'b1, addr: 4'd7, be: 4'b0010, data: 32'h1212_1212});
        repeat (3) miso_exp.push_back(8'h00);
        frame_start();
        xfer("w87_cmd", 8'h87, 8);
        xfer("w87_d0", 8'h34, 8);
        xfer("w87_d1", 8'h12, 8);
        frame_end();
        check_eq("w87_reads", rd_cnt - rd0, 0);
        check_eq("w87_writes", wr_cnt - wr0, 2);

        // Read 0x09, 4 dummy bytes
        rd0 = rd_cnt; wr0 = wr_cnt;
        rdata = 32'h0000_00A5;
        sb.push_back('{wr: 1'b0, addr: 4'd9, be: 4'b0000, data: 32'h0});
        miso_exp.push_back(8'h00);
        miso_exp.push_back(8'hA5);
        repeat (3) miso_exp.push_back(8'h00);
        frame_start();
        xfer("r09_cmd", 8'h09, 8);
        for (int k = 0; k < 4; k++) xfer("r09_data", 8'h00, 8);
        frame_end();
        check_eq("r09_reads", rd_cnt - rd0, 1);
        check_eq("r09_writes", wr_cnt - wr0, 0);
        check_eq("r09_addr_hold", {60'd0, csr_if.csr_address}, 64'd9);

        // Read 0x00, six bytes clocked (last two in OVER)
        rd0 = rd_cnt;
        rdata = 32'h0000_000E;
        sb.push_back('{wr: 1'b0, addr: 4'd0, be: 4'b0000, data: 32'h0});
        miso_exp.push_back(8'h00);
        miso_exp.push_back(8'h0E);
        repeat (5) miso_exp.push_back(8'h00);
        frame_start();
        xfer("r00_cmd", 8'h00, 8);
        for (int k = 0; k < 6; k++) xfer("r00_data", 8'hFF, 8);
        frame_end();
        check_eq("r00_reads", rd_cnt - rd0, 1);

        // Write 0x81 aborted after 5 data bits, then write 0x82 / 0xFF
        wr0 = wr_cnt;
        miso_exp.push_back(8'h00);
        frame_start();
        xfer("w81_cmd", 8'h81, 8);
        xfer("w81_part", 8'hC3, 5);
        frame_end();
        check_eq("w81_no_write", wr_cnt - wr0, 0);
        sb.push_back('{wr: 1'b1, addr: 4'd2, be: 4'b0001, data: 32'hFFFF_FFFF});
        repeat (2) miso_exp.push_back(8'h00);
        frame_start();
        xfer("w82_cmd", 8'h82, 8);
        xfer("w82_d0", 8'hFF, 8);
        frame_end();
        check_eq("w82_writes", wr_cnt - wr0, 1);

        // Reset pulsed during the second data byte of a write frame
        sb.push_back('{wr: 1'b1, addr: 4'd3, be: 4'b0001, data: 32'h1111_1111});
        repeat (3) miso_exp.push_back(8'h00);
        frame_start();
        xfer("w83_cmd", 8'h83, 8);
        xfer("w83_d0", 8'h11, 8);
        xfer("w83_d1a", 8'h55, 3);
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check_idle_outputs("midrst");
        reset_n = 1'b1;
        rd0 = rd_cnt; wr0 = wr_cnt;
        xfer("w83_d1b", 8'h55, 5);
        xfer("w83_tail", 8'hA1, 8);
        frame_end();
        check_eq("postrst_reads", rd_cnt - rd0, 0);
        check_eq("postrst_writes", wr_cnt - wr0, 0);
        check_eq("postrst_addr", {60'd0, csr_if.csr_address}, 64'd0);
        sb.push_back('{wr: 1'b1, addr: 4'd5, be: 4'b0001, data: 32'h7777_7777});
        repeat (2) miso_exp.push_back(8'h00);
        frame_start();
        xfer("w85_cmd", 8'h85, 8);
        xfer("w85_d0", 8'h77, 8);
        frame_end();
        check_eq("w85_writes", wr_cnt - wr0, 1);

        // sclk toggled with nss high
        rd0 = rd_cnt; wr0 = wr_cnt;
        nss_high_window = 1'b1;
        for (int k = 0; k < 16; k++) begin
            mosi = 1'($urandom_range(0, 1));
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (2 * HALF) @(negedge clk);
        nss_high_window = 1'b0;
        check_eq("idle_sclk_reads", rd_cnt - rd0, 0);
        check_eq("idle_sclk_writes", wr_cnt - wr0, 0);
        check_eq("idle_sclk_miso_en", en_bad_cnt, 0);

        // Global invariants and scoreboard drain
        check_eq("sb_empty", sb.size(), 0);
        check_eq("miso_exp_empty", miso_exp.size(), 0);
        check_eq("unexpected_strobes", unexp_cnt, 0);
        check_eq("read_write_overlap", both_cnt, 0);
        check_eq("be_without_write", bad_be_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
